// File: rtl/uart_tx_if.sv
// uart_tx_if : host-side handshake bundle between the control register logic
// and the UART transmitter (write strobe, data byte and status flags).
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_overrun;

  modport master (
    output tx_data,
    output new_tx_data,
    input  tx_ready,
    input  tx_busy,
    input  tx_overrun
  );

  modport slave (
    input  tx_data,
    input  new_tx_data,
    output tx_ready,
    output tx_busy,
    output tx_overrun
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx : 8-bit UART transmitter driven by a 16x baud enable (ce_16).
// A one-byte holding register feeds the shifter so frames can go out
// back-to-back. Optional even-parity bit compiled in with UART_TX_PARITY_EN.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | line idle high, waiting for a full holding register
// ST_START  | driving the start bit (0)
// ST_DATA   | driving data bits 0..7, LSB first
// ST_PARITY | driving even parity of the byte (UART_TX_PARITY_EN only)
// ST_STOP   | driving 1 or 2 stop bits (1)
module uart_tx #(
  parameter int STOP_BITS = 1
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      ce_16,
  uart_tx_if.slave  bus,
  output logic      ser_out
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [2:0] state;
  logic [3:0] sub_cnt;
  logic [2:0] bit_idx;
  logic       stop_cnt;
  logic [7:0] shreg;
  logic [7:0] hold;
  logic       hold_full;
  logic       busy_q;
  logic       overrun_q;

  logic bit_end;
  logic stop_last;
  logic frame_end;
  logic load;
  logic write_ok;

  // The second stop bit is only counted when two stop bits are configured.
  assign stop_last = (STOP_BITS == 1) || stop_cnt;
  assign bit_end   = ce_16 && (sub_cnt == 4'hF) && (state != ST_IDLE);
  assign frame_end = bit_end && (state == ST_STOP) && stop_last;
  // Transfer from holding to shifter: either from idle or seamlessly at frame end.
  assign load      = hold_full && ((state == ST_IDLE) || frame_end);
  assign write_ok  = bus.new_tx_data && !hold_full;

  assign bus.tx_ready   = ~hold_full;
  assign bus.tx_busy    = busy_q;
  assign bus.tx_overrun = overrun_q;

  // Holding register: capture on accepted write, empty on transfer, flag overruns.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold      <= 8'h00;
      hold_full <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= bus.new_tx_data && hold_full;
      if (load) begin
        hold_full <= 1'b0;
      end else if (write_ok) begin
        hold      <= bus.tx_data;
        hold_full <= 1'b1;
      end
    end
  end

  // Frame sequencer: sub-bit counter, bit index and registered serial line.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      sub_cnt  <= 4'd0;
      bit_idx  <= 3'd0;
      stop_cnt <= 1'b0;
      shreg    <= 8'h00;
      ser_out  <= 1'b1;
      busy_q   <= 1'b0;
    end else if (load) begin
      state    <= ST_START;
      shreg    <= hold;
      ser_out  <= 1'b0;
      busy_q   <= 1'b1;
      sub_cnt  <= 4'd0;
      bit_idx  <= 3'd0;
      stop_cnt <= 1'b0;
    end else if ((state != ST_IDLE) && ce_16) begin
      sub_cnt <= sub_cnt + 4'd1;
      if (sub_cnt == 4'hF) begin
        case (state)
          ST_START: begin
            state   <= ST_DATA;
            bit_idx <= 3'd0;
            ser_out <= shreg[0];
          end
          ST_DATA: begin
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state   <= ST_PARITY;
              ser_out <= ^shreg;
`else
              state    <= ST_STOP;
              ser_out  <= 1'b1;
              stop_cnt <= 1'b0;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              ser_out <= shreg[bit_idx + 3'd1];
            end
          end
`ifdef UART_TX_PARITY_EN
          ST_PARITY: begin
            state    <= ST_STOP;
            ser_out  <= 1'b1;
            stop_cnt <= 1'b0;
          end
`endif
          ST_STOP: begin
            if (!stop_last) begin
              stop_cnt <= 1'b1;
            end else begin
              state   <= ST_IDLE;
              busy_q  <= 1'b0;
              ser_out <= 1'b1;
            end
          end
          default: begin
            state   <= ST_IDLE;
            busy_q  <= 1'b0;
            ser_out <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx : directed bench for uart_tx with a byte scoreboard and a
// serial-line monitor that decodes frames and compares them against it.
`timescale 1ns/1ps
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
  localparam int STOP = 2;
  localparam int PAR  = 1;
`else
  localparam int STOP = 1;
  localparam int PAR  = 0;
`endif
  localparam int FB     = 9 + PAR + STOP;
  localparam int BITCLK = 64;
  localparam int FL     = FB * BITCLK;
  localparam int NONE   = -10;

  logic clock = 1'b0;
  logic reset;
  logic ce_16;
  logic ce_en;
  logic ser_out;
  int   ce_cnt;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] exp_q[$];

  uart_tx_if bus();

  uart_tx #(.STOP_BITS(STOP)) dut (
    .clock   (clock),
    .reset   (reset),
    .ce_16   (ce_16),
    .bus     (bus),
    .ser_out (ser_out)
  );

  always #5 clock = ~clock;

  // ce_16 every 4 clocks, driven just after the falling edge
  initial begin
    ce_cnt = 0;
    ce_16  = 1'b0;
    forever begin
      @(negedge clock);
      ce_cnt = (ce_cnt + 1) % 4;
      ce_16  = ce_en && (ce_cnt == 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (PAR == 1 && i == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // Write to an idle transmitter so the transfer edge coincides with a ce_16
  // pulse; returns at the sample point just after the transfer edge.
  task automatic write_start(input logic [7:0] b);
    for (int i = 0; i < 8 && ce_cnt != 3; i++) step();
    bus.tx_data     = b;
    bus.new_tx_data = 1'b1;
    chk("wr_ready", bus.tx_ready, 1);
    exp_q.push_back(b);
    step();
    bus.new_tx_data = 1'b0;
    chk("ready_low_one_cycle", bus.tx_ready, 0);
    chk("line_idle_before_start", ser_out, 1);
    chk("busy_before_start", bus.tx_busy, 0);
    step();
    chk("ready_back", bus.tx_ready, 1);
    chk("busy_rise", bus.tx_busy, 1);
  endtask

  // Check a full frame clock by clock, with up to two writes injected at
  // frame-relative clock offsets; ends at the sample after the frame-end edge.
  task automatic check_frame(input logic [7:0] b,
                             input int w1_at, input logic [7:0] w1_d, input bit w1_ok,
                             input int w2_at, input logic [7:0] w2_d, input bit w2_ok);
    int mism = 0;
    bit busy_ok = 1'b1;
    bit next_full = 1'b0;
    for (int c = 0; c < FL; c++) begin
      if (ser_out !== exp_bit(b, c / BITCLK)) mism++;
      if (bus.tx_busy !== 1'b1) busy_ok = 1'b0;
      if (c == w1_at + 1) begin
        bus.new_tx_data = 1'b0;
        chk("overrun_w1", bus.tx_overrun, {31'd0, !w1_ok});
      end
      if (c == w2_at + 1) begin
        bus.new_tx_data = 1'b0;
        chk("overrun_w2", bus.tx_overrun, {31'd0, !w2_ok});
      end
      if (c == w1_at + 2 || c == w2_at + 2) chk("overrun_one_cycle", bus.tx_overrun, 0);
      if (c == w1_at) begin
        bus.tx_data = w1_d;
        bus.new_tx_data = 1'b1;
        chk("w1_ready", bus.tx_ready, {31'd0, w1_ok});
        if (w1_ok) begin exp_q.push_back(w1_d); next_full = 1'b1; end
      end
      if (c == w2_at) begin
        bus.tx_data = w2_d;
        bus.new_tx_data = 1'b1;
        chk("w2_ready", bus.tx_ready, {31'd0, w2_ok});
        if (w2_ok) begin exp_q.push_back(w2_d); next_full = 1'b1; end
      end
      if (c % BITCLK == BITCLK - 1) begin
        chk($sformatf("frame_%02h_bit%0d", b, c / BITCLK), mism, 0);
        mism = 0;
      end
      step();
    end
    chk("busy_held_frame", {31'd0, busy_ok}, 1);
    chk("ready_at_frame_end", bus.tx_ready, 1);
    if (next_full) begin
      chk("b2b_start_no_gap", ser_out, 0);
      chk("b2b_busy_stays", bus.tx_busy, 1);
    end else begin
      chk("end_line_high", ser_out, 1);
      chk("end_busy_fall", bus.tx_busy, 0);
    end
  endtask

  // Serial-line monitor: mid-bit sampling, compares each decoded byte with the scoreboard
  initial begin : mon
    int cnt;
    int i;
    bit in_f;
    logic [7:0] d;
    logic [7:0] e;
    logic pb;
    in_f = 1'b0;
    cnt = 0;
    d = 8'h00;
    pb = 1'b0;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1) begin
        in_f = 1'b0;
      end else if (!in_f) begin
        if (ser_out === 1'b0) begin
          in_f = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt++;
      end
      if (in_f && reset === 1'b1 && (cnt % BITCLK == BITCLK / 2)) begin
        i = cnt / BITCLK;
        if (i == 0) chk("mon_start", ser_out, 0);
        else if (i <= 8) d[i-1] = ser_out;
        else if (PAR == 1 && i == 9) pb = ser_out;
        else begin
          chk("mon_stop", ser_out, 1);
          if (i == FB - 1) begin
            in_f = 1'b0;
            if (exp_q.size() == 0) begin
              chk("mon_unexpected_frame", 1, 0);
            end else begin
              e = exp_q.pop_front();
              chk("mon_data", d, e);
`ifdef UART_TX_PARITY_EN
              chk("mon_parity", pb, ^e);
`endif
            end
          end
        end
      end
    end
  end

  initial begin : stim
    int bad;
    reset = 1'b0;
    ce_en = 1'b1;
    bus.tx_data = 8'h00;
    bus.new_tx_data = 1'b0;

    // 1. reset with random inputs and ce_16 running
    bad = 0;
    for (int k = 0; k < 24; k++) begin
      step();
      bus.new_tx_data = 1'($urandom_range(0, 1));
      bus.tx_data = 8'($urandom_range(0, 255));
      if (ser_out !== 1'b1 || bus.tx_ready !== 1'b1 || bus.tx_busy !== 1'b0 ||
          bus.tx_overrun !== 1'b0) bad++;
    end
    chk("reset_outputs", bad, 0);
    bus.new_tx_data = 1'b0;
    reset = 1'b1;
    step();
    chk("post_reset_line", ser_out, 1);
    chk("post_reset_ready", bus.tx_ready, 1);
    repeat (10) step();
    chk("idle_ce_no_effect", ser_out, 1);

    // 2. single frame 0x55
    write_start(8'h55);
    check_frame(8'h55, NONE, 8'h00, 1'b0, NONE, 8'h00, 1'b0);
    repeat (20) step();

    // 3. back-to-back 0xA3 then 0x0F, plus an overrun with 0xFF while holding is full
    write_start(8'hA3);
    check_frame(8'hA3, 200, 8'h0F, 1'b1, 300, 8'hFF, 1'b0);
    check_frame(8'h0F, NONE, 8'h00, 1'b0, NONE, 8'h00, 1'b0);
    repeat (20) step();

    // 4. overrun on the same edge as the idle transfer
    for (int k = 0; k < 8 && ce_cnt != 3; k++) step();
    bus.tx_data = 8'h3C;
    bus.new_tx_data = 1'b1;
    chk("ov_wr_ready", bus.tx_ready, 1);
    exp_q.push_back(8'h3C);
    step();
    chk("ov_ready_low", bus.tx_ready, 0);
    bus.tx_data = 8'hFF;
    step();
    chk("ov_pulse", bus.tx_overrun, 1);
    chk("ov_ready_after_transfer", bus.tx_ready, 1);
    chk("ov_start_bit", ser_out, 0);
    bus.new_tx_data = 1'b0;
    step();
    chk("ov_pulse_ends", bus.tx_overrun, 0);
    repeat (FL) step();
    chk("ov_frame_done", bus.tx_busy, 0);
    repeat (20) step();

`ifdef UART_TX_PARITY_EN
    // 5. parity frame, two stop bits
    write_start(8'h07);
    check_frame(8'h07, NONE, 8'h00, 1'b0, NONE, 8'h00, 1'b0);
    repeat (20) step();
`endif

    // 6. reset in the middle of data bit 4 (bit 4 of 0x25 is 0)
    write_start(8'h25);
    repeat (4 * BITCLK + BITCLK + BITCLK / 2) step();
    chk("mid_bit4_level", ser_out, 0);
    reset = 1'b0;
    #1;
    chk("async_reset_line", ser_out, 1);
    chk("async_reset_busy", bus.tx_busy, 0);
    chk("async_reset_ready", bus.tx_ready, 1);
    void'(exp_q.pop_front());
    step();
    reset = 1'b1;
    bad = 0;
    for (int k = 0; k < 150; k++) begin
      step();
      if (ser_out !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_ready !== 1'b1) bad++;
    end
    chk("no_resume_after_reset", bad, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that consumes the 16x-oversampled `ce_16` enable from the baud generator and shifts out one 8-bit UART frame (start bit, LSB-first data, optional parity, stop bits). A one-byte holding register in front of the shift register accepts the next byte while the current frame is on the line, so consecutive frames go out back-to-back. The block sits between the control register logic and the UART TX pin.

## Interface

- `STOP_BITS`, default 1. Number of stop bits: 1 or 2 only.
- `clock`  in  1  system clock; the same clock that drives the baud generator.
- `reset`  in  1  asynchronous, active-low reset.
- `ce_16`  in  1  one-cycle enable pulse at 16x baud rate.
- `tx_data`  in  8  byte to send; sampled when the write is accepted.
- `new_tx_data`  in  1  write strobe; accepted only when `tx_ready`=1.
- `tx_ready`  out  1  holding register empty; a write is accepted this cycle.
- `tx_busy`  out  1  shifter is transmitting a frame (start through stop).
- `tx_overrun`  out  1  one-cycle pulse: write attempted while `tx_ready`=0.
- `ser_out`  out  1  serial line, registered, idle high.

## Operation

- Holding register:
  - When `new_tx_data`=1 and `tx_ready`=1 at edge N, the holding register captures `tx_data` and `tx_ready`<=0.
  - When `new_tx_data`=1 and `tx_ready`=0, the write is dropped, the holding contents are unchanged, and `tx_overrun`<=1 for exactly one cycle.
- Transfer to shifter:
  - Condition: holding full and shifter in IDLE.
  - On the next edge: shifter loads the byte, holding empties (`tx_ready`<=1), state<=START, `ser_out`<=0, `tx_busy`<=1, sub-bit counter<=0.
  - A write and a transfer may fall on the same edge. A write is accepted only if `tx_ready`=1 before that edge.
- State machine:
  - States: IDLE, START, DATA, PARITY (only with the macro), STOP.
  - A 4-bit sub-bit counter increments on each `ce_16` in every state except IDLE. `ce_16` has no effect in IDLE.
  - A bit ends on the `ce_16` where the counter is 15. The counter wraps to 0 and the next bit value is driven on `ser_out` at that same edge.
  - Transitions:
    - START -> DATA.
    - DATA: a 3-bit index runs 0..7, sending bit 0 first. After bit 7, go to PARITY or STOP.
    - PARITY -> STOP.
    - STOP lasts 16*`STOP_BITS` `ce_16` pulses; with `STOP_BITS`=2 a stop-count bit extends the counting.
  - End of STOP with holding full: go directly to START (`ser_out`<=0, load shifter, `tx_ready`<=1). `tx_busy` stays 1, so there is zero idle gap.
  - End of STOP with holding empty: go to IDLE, `tx_busy`<=0, `ser_out` stays 1.
- Reset (asserted, asynchronous):
  - `ser_out`=1, `tx_ready`=1, `tx_busy`=0, `tx_overrun`=0; state IDLE; counters 0; holding empty.
  - Reset mid-frame aborts the frame immediately. No partial frame resumes after release.

## Timing

- Write-to-start latency: write accepted at edge N -> start bit driven at edge N+1, provided the shifter is idle.
- Bit period is 16 `ce_16` pulses. With `ce_16` every K clocks, one bit = 16*K clocks.
- Frame length is (1+8+P+`STOP_BITS`) bit periods, where P=1 with the macro and 0 without.
- `tx_ready` is low for exactly one cycle when the write lands on an idle shifter.
- `ser_out` changes only on a clock edge coincident with a counted `ce_16`, or at a transfer edge. It is glitch-free.

## Configuration

- `UART_TX_PARITY_EN` defined:
  - The PARITY state is compiled in and emits an even-parity bit (XOR of the 8 data bits) after data bit 7.
  - Frame = 1+8+1+`STOP_BITS` bits.
- Undefined:
  - No PARITY state or logic; DATA goes directly to STOP.
  - Frame = 1+8+`STOP_BITS` bits.

## Test plan

1. Reset: hold `reset`=0 with random inputs -> `ser_out`=1, `tx_ready`=1, `tx_busy`=0, `tx_overrun`=0. Toggling `ce_16` leaves `ser_out` at 1.
2. Single frame (`ce_16` every 4 clocks, `STOP_BITS`=1, no parity): write 0x55 at edge N.
   - Required: `ser_out`=0 from N+1 for 64 clocks, then 1,0,1,0,1,0,1,0 at 64 clocks each, then stop=1.
   - `tx_busy` falls 640 clocks after N+1.
3. Back-to-back: write 0xA3, then write 0x0F while the first frame is in DATA.
   - Required: the 0x0F start bit begins on the edge ending the 0xA3 stop bit, with no idle cycles.
   - `tx_busy` stays 1 throughout.
   - `tx_ready` returns to 1 at that edge.
4. Overrun: with holding full, pulse `new_tx_data` with 0xFF.
   - Required: `tx_overrun`=1 for one cycle.
   - The transmitted byte is the original one, not 0xFF.
5. Parity (`UART_TX_PARITY_EN`, `STOP_BITS`=2): send 0x07.
   - Required: 12-bit frame with parity bit=1.
   - Stop level held for 32 `ce_16` pulses.
6. Reset mid-frame: assert `reset` during data bit 4.
   - Required: `ser_out`=1 asynchronously, before the next edge.
   - After release the block stays in IDLE with `tx_ready`=1 and `ser_out`=1.
